// File: rtl/fighter_anim_ctrl_pkg.sv
// Shared types and constants for the fighter animation sequencer and the sprite draw mux.
package fighter_pkg;
  localparam int TICKS_PER_FRAME = 6;
  localparam int WALK_FRAMES     = 4;
  localparam int PUNCH_FRAMES    = 3;
  localparam int HITSTUN_TICKS   = 20;
  localparam int JUMP_V          = 12;
  localparam int GRAVITY         = 1;
  localparam int TICK_W          = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    JUMP    = 3'd2,
    PUNCH   = 3'd3,
    HITSTUN = 3'd4
  } anim_state_t;

  typedef enum logic [3:0] {
    SPR_IDLE, SPR_WALK, SPR_JUMP1, SPR_JUMP2, SPR_JUMP3, SPR_JUMP4, SPR_PUNCH, SPR_HITSTUN
  } sprite_sel_t;

  // Jump has one ROM per arc phase; everything else is one ROM indexed by frame.
  function automatic sprite_sel_t sprite_sel(input anim_state_t st, input logic [2:0] frame);
    case (st)
      WALK:    return SPR_WALK;
      PUNCH:   return SPR_PUNCH;
      HITSTUN: return SPR_HITSTUN;
      JUMP: begin
        case (frame[1:0])
          2'd0:    return SPR_JUMP1;
          2'd1:    return SPR_JUMP2;
          2'd2:    return SPR_JUMP3;
          default: return SPR_JUMP4;
        endcase
      end
      default: return SPR_IDLE;
    endcase
  endfunction

  function automatic logic [2:0] jump_frame(input logic signed [7:0] vy);
    if (int'(vy) > JUMP_V / 2)         return 3'd0;
    else if (int'(vy) > 0)             return 3'd1;
    else if (int'(vy) > -(JUMP_V / 2)) return 3'd2;
    else                               return 3'd3;
  endfunction
endpackage

// File: rtl/fighter_anim_ctrl_if.sv
// Command/status bundle between game logic and one fighter's animation sequencer.
interface fighter_anim_ctrl_if;
  import fighter_pkg::*;
  logic        frame_tick;
  logic        cmd_left, cmd_right, cmd_jump, cmd_punch;
  logic        face_left;
  logic        hit;
  anim_state_t anim_state;
  logic [2:0]  frame_idx;
  logic        mirror;
  logic [7:0]  y_offset;
  logic        busy;
  logic        anim_done;

  modport master (
    output frame_tick, cmd_left, cmd_right, cmd_jump, cmd_punch, face_left, hit,
    input  anim_state, frame_idx, mirror, y_offset, busy, anim_done
  );
  modport slave (
    input  frame_tick, cmd_left, cmd_right, cmd_jump, cmd_punch, face_left, hit,
    output anim_state, frame_idx, mirror, y_offset, busy, anim_done
  );
endinterface

// File: rtl/fighter_anim_ctrl_jump_physics.sv
// Per-tick ballistic integrator: owns vertical velocity and height above ground.
module jump_physics
  import fighter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_step,
  output logic [7:0]        o_y_offset,
  output logic signed [7:0] o_vy,
  output logic              o_landed
);
  logic [7:0]        r_y;
  logic signed [7:0] r_vy;
  logic signed [9:0] w_sum;

  // Two guard bits so a 255 height plus positive velocity cannot wrap negative.
  assign w_sum      = $signed({2'b00, r_y}) + $signed({{2{r_vy[7]}}, r_vy});
  assign o_landed   = (w_sum <= 10'sd0);
  assign o_y_offset = r_y;
  assign o_vy       = r_vy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y  <= '0;
      r_vy <= '0;
    end else if (i_start) begin
      r_y  <= '0;
      r_vy <= 8'(JUMP_V);
    end else if (i_step) begin
      if (o_landed) begin
        r_y  <= '0;
        r_vy <= '0;
      end else begin
        r_y  <= (w_sum > 10'sd255) ? 8'hFF : w_sum[7:0];
        r_vy <= r_vy - 8'(GRAVITY);
      end
    end
  end
endmodule

// File: rtl/fighter_anim_ctrl.sv
// Frame-locked animation FSM: picks state, frame, mirror and jump height once per frame_tick.
module fighter_anim_ctrl
  import fighter_pkg::*;
(
  input logic                vga_clk,
  input logic                Reset,
  fighter_anim_ctrl_if.slave bus
);
  anim_state_t       r_state;
  logic [2:0]        r_frame;
  logic [TICK_W-1:0] r_tick;
  logic              r_mirror, r_busy, r_done, r_hit_pend;
  logic              w_hit, w_idle_walk, w_jstart, w_jstep, w_landed;
  logic [7:0]        w_y;
  logic signed [7:0] w_vy, w_vy_next;

  assign w_idle_walk = (r_state == IDLE) || (r_state == WALK);
  assign w_hit       = r_hit_pend | bus.hit;
  assign w_jstart    = bus.frame_tick && w_idle_walk && !w_hit && bus.cmd_jump;
  assign w_jstep     = bus.frame_tick && (r_state == JUMP);
  assign w_vy_next   = w_vy - 8'(GRAVITY);

  jump_physics u_jump (
    .i_clk      (vga_clk),
    .i_rst      (Reset),
    .i_start    (w_jstart),
    .i_step     (w_jstep),
    .o_y_offset (w_y),
    .o_vy       (w_vy),
    .o_landed   (w_landed)
  );

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_frame    <= '0;
      r_tick     <= '0;
      r_mirror   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hit_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.hit && r_state != HITSTUN) r_hit_pend <= 1'b1;
      if (bus.frame_tick) begin
        case (r_state)
          IDLE, WALK: begin
            r_mirror <= bus.face_left;
            r_tick   <= '0;
            r_frame  <= '0;
            if (w_hit) begin
              r_state    <= HITSTUN;
              r_busy     <= 1'b1;
              r_hit_pend <= 1'b0;
            end else if (bus.cmd_jump) begin
              r_state <= JUMP;
              r_busy  <= 1'b1;
            end else if (bus.cmd_punch) begin
              r_state <= PUNCH;
              r_busy  <= 1'b1;
            end else if (bus.cmd_left ^ bus.cmd_right) begin
              r_state <= WALK;
              r_busy  <= 1'b0;
              // Walk cycle keeps its phase while the walk persists.
              if (r_state == WALK) begin
                if (r_tick == TICK_W'(TICKS_PER_FRAME - 1))
                  r_frame <= (r_frame == 3'(WALK_FRAMES - 1)) ? 3'd0 : r_frame + 3'd1;
                else begin
                  r_tick  <= r_tick + 1'b1;
                  r_frame <= r_frame;
                end
              end
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          JUMP: begin
            if (w_landed) begin
              r_done  <= 1'b1;
              r_tick  <= '0;
              r_frame <= '0;
              if (w_hit) begin
                r_state    <= HITSTUN;
                r_hit_pend <= 1'b0;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_frame <= jump_frame(w_vy_next);
            end
          end
          PUNCH: begin
            if (r_tick == TICK_W'(TICKS_PER_FRAME - 1)) begin
              r_tick <= '0;
              if (r_frame == 3'(PUNCH_FRAMES - 1)) begin
                r_done  <= 1'b1;
                r_frame <= '0;
                if (w_hit) begin
                  r_state    <= HITSTUN;
                  r_hit_pend <= 1'b0;
                end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_frame <= r_frame + 3'd1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          default: begin
            if (r_tick == TICK_W'(HITSTUN_TICKS - 1)) begin
              r_done  <= 1'b1;
              r_tick  <= '0;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.anim_state = r_state;
  assign bus.frame_idx  = r_frame;
  assign bus.mirror     = r_mirror;
  assign bus.y_offset   = w_y;
  assign bus.busy       = r_busy;
  assign bus.anim_done  = r_done;
endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Scenario tasks plus randomized ticks, all checked against a tick-level behavioural model.
module tb_fighter_anim_ctrl;
  import fighter_pkg::*;

  logic vga_clk = 1'b0;
  logic Reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  fighter_anim_ctrl_if bus();
  fighter_anim_ctrl dut (.vga_clk(vga_clk), .Reset(Reset), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  int exp_y[25] = '{12,23,33,42,50,57,63,68,72,75,77,78,78,77,75,72,68,63,57,50,42,33,23,12,0};

  // Model: state plus ticks elapsed since entering it; everything else is derived.
  anim_state_t m_state;
  int          m_k;
  bit          m_mirror, m_pend, m_done;

  function automatic int jump_y(input int k);
    int y;
    y = JUMP_V * k - GRAVITY * k * (k - 1) / 2;
    return (y > 255) ? 255 : y;
  endfunction

  function automatic int exp_frame();
    int v;
    case (m_state)
      WALK:  return (m_k / TICKS_PER_FRAME) % WALK_FRAMES;
      PUNCH: return m_k / TICKS_PER_FRAME;
      JUMP: begin
        if (m_k == 0) return 0;
        v = JUMP_V - GRAVITY * m_k;
        if (v > JUMP_V / 2) return 0;
        if (v > 0) return 1;
        if (v > -(JUMP_V / 2)) return 2;
        return 3;
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [16:0] exp_vec();
    int y;
    bit b;
    y = (m_state == JUMP) ? jump_y(m_k) : 0;
    b = (m_state == JUMP) || (m_state == PUNCH) || (m_state == HITSTUN);
    return {m_state, 3'(exp_frame()), m_mirror, 8'(y), b, m_done};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.anim_state, bus.frame_idx, bus.mirror, bus.y_offset, bus.busy, bus.anim_done};
  endfunction

  task automatic enter(input anim_state_t s);
    m_state = s;
    m_k     = 0;
    if (s == HITSTUN) m_pend = 1'b0;
  endtask

  task automatic model_reset();
    m_state = IDLE; m_k = 0; m_mirror = 0; m_pend = 0; m_done = 0;
  endtask

  task automatic model_tick(input bit l, r, j, p, f, h);
    bit hn;
    hn = m_pend | (h && m_state != HITSTUN);
    if (m_state != HITSTUN) m_pend = hn;
    m_done = 1'b0;
    case (m_state)
      IDLE, WALK: begin
        m_mirror = f;
        if (hn) enter(HITSTUN);
        else if (j) enter(JUMP);
        else if (p) enter(PUNCH);
        else if (l ^ r) begin
          if (m_state == WALK) m_k++;
          else enter(WALK);
        end else enter(IDLE);
      end
      JUMP: begin
        m_k++;
        if (jump_y(m_k) <= 0) begin m_done = 1'b1; enter(hn ? HITSTUN : IDLE); end
      end
      PUNCH: begin
        m_k++;
        if (m_k == TICKS_PER_FRAME * PUNCH_FRAMES) begin m_done = 1'b1; enter(hn ? HITSTUN : IDLE); end
      end
      default: begin
        m_k++;
        if (m_k == HITSTUN_TICKS) begin m_done = 1'b1; enter(IDLE); end
      end
    endcase
  endtask

  // Called at a negedge; returns at the next negedge with the tick's results visible.
  task automatic drive_tick(input bit l, r, j, p, f, h);
    bus.cmd_left = l; bus.cmd_right = r; bus.cmd_jump = j; bus.cmd_punch = p;
    bus.face_left = f; bus.hit = h; bus.frame_tick = 1'b1;
    @(negedge vga_clk);
    bus.frame_tick = 1'b0; bus.hit = 1'b0;
    model_tick(l, r, j, p, f, h);
  endtask

  task automatic gap(input int n, input int hit_at);
    for (int i = 0; i < n; i++) begin
      bus.hit = (i == hit_at);
      if (bus.hit && m_state != HITSTUN) m_pend = 1'b1;
      @(negedge vga_clk);
      bus.hit = 1'b0;
      m_done  = 1'b0;
    end
  endtask

  task automatic test_reset();
    {bus.frame_tick, bus.cmd_left, bus.cmd_right, bus.cmd_jump, bus.cmd_punch, bus.face_left, bus.hit} = '0;
    Reset = 1'b1;
    repeat (3) @(negedge vga_clk);
    model_reset();
    n_chk++;
    if (obs_vec() !== 17'd0) begin
      n_fail++; $display("FAIL reset_state: got %h exp %h", obs_vec(), 17'd0);
    end
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_tick(0, 0, 0, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL idle_tick%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
      gap(1, -1);
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 30; i++) begin
      drive_tick(0, 1, 0, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL walk_tick%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
      n_chk++;
      if (bus.frame_idx !== 3'((i / 6) % 4) || bus.anim_state !== WALK) begin
        n_fail++; $display("FAIL walk_frame%0d: got %0d exp %0d", i, bus.frame_idx, (i / 6) % 4);
      end
      gap(2, -1);
    end
    drive_tick(1, 1, 0, 0, 0, 0);
    n_chk++;
    if (bus.anim_state !== IDLE || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL walk_both_dirs: got %h exp %h", obs_vec(), exp_vec());
    end
    gap(1, -1);
  endtask

  task automatic test_jump();
    drive_tick(0, 0, 1, 0, 1, 0);
    n_chk++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL jump_entry: got %h exp %h", obs_vec(), exp_vec());
    end
    for (int n = 1; n <= 25; n++) begin
      gap(2, -1);
      drive_tick(0, 0, 0, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL jump_tick%0d: got %h exp %h", n, obs_vec(), exp_vec());
      end
      n_chk++;
      if (bus.y_offset !== 8'(exp_y[n-1]) || bus.mirror !== 1'b1) begin
        n_fail++; $display("FAIL jump_arc%0d: y %0d mirror %0d, exp y %0d mirror 1",
                           n, bus.y_offset, bus.mirror, exp_y[n-1]);
      end
      n_chk++;
      if (bus.anim_done !== (n == 25)) begin
        n_fail++; $display("FAIL jump_done%0d: got %0d exp %0d", n, bus.anim_done, n == 25);
      end
    end
    gap(1, -1);
  endtask

  task automatic test_jump_hit();
    int guard;
    drive_tick(0, 0, 1, 0, 0, 0);
    for (int n = 1; n <= 5; n++) drive_tick(0, 0, 0, 0, 0, 0);
    gap(3, 1);
    guard = 0;
    while (!(m_state == IDLE && m_done) && guard < 60) begin
      drive_tick(0, 0, 0, 0, 0, 0);
      guard++;
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL jump_hit_tick%0d: got %h exp %h", guard, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (guard != 20 + 20 || bus.anim_state !== IDLE || bus.anim_done !== 1'b1) begin
      n_fail++; $display("FAIL jump_hit_exit: ticks %0d state %0d done %0d, exp ticks 40 state 0 done 1",
                         guard, bus.anim_state, bus.anim_done);
    end
    gap(1, -1);
  endtask

  task automatic test_punch();
    drive_tick(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL punch_entry: got %h exp %h", obs_vec(), exp_vec());
    end
    for (int i = 1; i <= 18; i++) begin
      drive_tick(0, 0, 1, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL punch_tick%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (bus.anim_state !== IDLE || bus.anim_done !== 1'b1) begin
      n_fail++; $display("FAIL punch_exit: state %0d done %0d, exp state 0 done 1", bus.anim_state, bus.anim_done);
    end
    drive_tick(0, 0, 1, 0, 0, 0);
    n_chk++;
    if (bus.anim_state !== JUMP || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL punch_then_jump: got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_jump();
    for (int n = 1; n <= 12; n++) drive_tick(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (bus.y_offset !== 8'd78 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL jump_peak: got %h exp %h", obs_vec(), exp_vec());
    end
    Reset = 1'b1;
    @(negedge vga_clk);
    model_reset();
    n_chk++;
    if (bus.anim_state !== IDLE || bus.y_offset !== 8'd0 || bus.anim_done !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_mid_jump: got %h exp %h", obs_vec(), exp_vec());
    end
    Reset = 1'b0;
  endtask

  task automatic test_random();
    bit l, r, j, p, f, h;
    int g, ha;
    for (int i = 0; i < 400; i++) begin
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      j  = ($urandom_range(0, 9) == 0);
      p  = ($urandom_range(0, 7) == 0);
      f  = $urandom_range(0, 1);
      h  = ($urandom_range(0, 29) == 0);
      drive_tick(l, r, j, p, f, h);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand_tick%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
      g  = $urandom_range(0, 3);
      ha = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 3) : -1;
      if (g > 0) begin
        gap(g, ha);
        n_chk++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL rand_gap%0d: got %h exp %h", i, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_jump();
    test_jump_hit();
    test_punch();
    test_reset_mid_jump();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
